dlatch_tester: RTL and testbench
================================

Name: dlatch_tester

Overview:
- Hardware stimulus generator and checker for a level-sensitive D latch under test (DUT).
- It drives the DUT's enable (`c`) and data (`din`) inputs from a built-in vector sequence. It samples `qout`/`qbout` and compares them against an internal reference latch model.
- Results are reported as pass/fail, an error count and the index of the first failing vector.
- It sits beside the latch on the lab board or in a system-level bench, replacing a hand-written stimulus sequence.

Parameters:
- `NUM_VEC`, 15: number of vectors applied per run; range 1..255.
- `STEP_CYCLES`, 10: clock cycles each vector is held; must be at least 2.
- `SETTLE`, 2: cycle within a step at which DUT outputs are sampled; range 1..`STEP_CYCLES`-1.

Ports:
- `clk`: input, 1 bit. System clock; all state changes on the rising edge.
- `rst`: input, 1 bit. Asynchronous reset, active-high.
- `start`: input, 1 bit. Single-cycle run request, sampled in IDLE only.
- `qout`: input, 1 bit. DUT Q output.
- `qbout`: input, 1 bit. DUT Q-bar output.
- `c_out`: output, 1 bit. Registered drive to DUT enable `c`.
- `din_out`: output, 1 bit. Registered drive to DUT `din`.
- `busy`: output, 1 bit. High while a run is in progress.
- `done`: output, 1 bit. One-cycle pulse at end of run.
- `pass`: output, 1 bit. High when the last completed run had `err_cnt`==0.
- `err_cnt`: output, 8 bits. Mismatch count; saturates at 255.
- `fail_idx`: output, 8 bits. Index of the first failing vector; 8'hFF if none.

Behaviour:
- Reset (asynchronous, immediate):
  - `c_out`=0, `din_out`=0, `busy`=0, `done`=0, `pass`=0.
  - `err_cnt`=0, `fail_idx`=8'hFF, FSM state IDLE.
  - Reference model is cleared to invalid.
- Reset mid-run aborts the run with the same values; no `done` pulse is produced.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - `start`=1 moves to RUN on the next edge.
  - On that edge: vector index k=0, step counter sc=0, `err_cnt`=0, `fail_idx`=FF, `pass`=0, model invalid.
  - `busy` goes high the same edge.
- Vector k encoding, driven on the edge that enters step k:
  - `c_out` = (k mod 3 == 2). A mod-3 counter runs alongside k; no divider is used.
  - `din_out` = k[0] XOR k[2].
  - Outputs hold for exactly `STEP_CYCLES` cycles.
- Reference model:
  - When vector k has `c_out`=1, exp_q <= `din_out`(k) and the model becomes valid.
  - Otherwise exp_q holds.
- Sampling:
  - Occurs when sc==`SETTLE`, and only if the model is valid.
  - Mismatch if `qout`!=exp_q or `qbout`!=~exp_q. Each vector counts at most 1 error.
  - On mismatch, `err_cnt` increments (saturating at 255).
  - `fail_idx` is set to k only if it is still FF.
- Vectors before the first transparent vector are never compared.
- Step advance: sc counts 0..`STEP_CYCLES`-1. On wrap, k increments and sc returns to 0. The step after k=`NUM_VEC`-1 enters FINISH.
- FINISH (one cycle):
  - `c_out`=0, `din_out`=0, `busy`=0.
  - `done`=1 for that cycle only; `pass`=(`err_cnt`==0).
  - Returns to IDLE.
- Result holding: `err_cnt`, `fail_idx` and `pass` hold until the next accepted `start`.
- Run length: `busy` is high for exactly `NUM_VEC`*`STEP_CYCLES` cycles.
- `start` while RUN or FINISH is ignored and not queued.
- `start` high continuously in IDLE launches a new run immediately after FINISH.

Optional Feature:
- Macro: `DLATCH_TESTER_HALT_EN`.
- Defined: the first mismatch ends the run at the next edge. The FSM enters FINISH with `err_cnt`=1 and `fail_idx`=k; remaining vectors are skipped and `busy` drops early.
- Undefined: the run always completes all `NUM_VEC` vectors.

Test Plan:
- Correct latch DUT, default parameters, pulse `start`:
  - `busy` is high for 150 cycles, then `done` pulses.
  - Result: `pass`=1, `err_cnt`=0, `fail_idx`=FF.
- DUT with `qout` stuck at 0 and `qbout`=1:
  - Vectors 11..14 fail (exp_q=1).
  - Result: `err_cnt`=4, `fail_idx`=11, `pass`=0.
- DUT with `qbout` wired equal to `qout`:
  - All 13 compared vectors (2..14) fail.
  - Result: `err_cnt`=13, `fail_idx`=2.
- Assert `rst` during vector 6:
  - Immediately `c_out`=0, `din_out`=0, `busy`=0, `err_cnt`=0, `fail_idx`=FF.
  - No `done` pulse; a new `start` then runs a full 150-cycle pass.
- `start` pulsed again at cycle 40 of a run: ignored. `done` occurs at cycle 150 of the original run, and only once.
- With `DLATCH_TESTER_HALT_EN` and the stuck-0 DUT: `done` pulses right after the vector 11 sample, with `err_cnt`=1, `fail_idx`=11.

Source files
------------

// File: rtl/dlatch_tester.sv
// rtl/dlatch_tester.sv - stimulus generator and reference checker for a D latch under test
// Optional early stop on first mismatch: define DLATCH_TESTER_HALT_EN.
module dlatch_tester #(
  parameter int NUM_VEC     = 15,
  parameter int STEP_CYCLES = 10,
  parameter int SETTLE      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       qout,
  input  logic       qbout,
  output logic       c_out,
  output logic       din_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [7:0] fail_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  localparam int             SCW       = $clog2(STEP_CYCLES);
  localparam logic [SCW-1:0] SC_LAST   = SCW'(STEP_CYCLES - 1);
  localparam logic [SCW-1:0] SC_SAMPLE = SCW'(SETTLE);
  localparam logic [7:0]     K_LAST    = 8'(NUM_VEC - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [7:0]     r_k;
  logic [SCW-1:0] r_sc;
  logic [1:0]     r_mod3;
  logic           r_c;
  logic           r_din;
  logic           r_exp_q;
  logic           r_valid;
  logic [7:0]     r_err;
  logic [7:0]     r_fail;
  logic           r_pass;

  logic           w_step_end;
  logic           w_last_vec;
  logic           w_mismatch;
  logic           w_halt;
  logic           w_run_end;
  logic [7:0]     w_err_nxt;
  logic [7:0]     w_k_nxt;
  logic [1:0]     w_mod3_nxt;
  logic           w_din_nxt;

  assign w_step_end = (r_sc == SC_LAST);
  assign w_last_vec = (r_k == K_LAST);
  assign w_mismatch = (r_state == S_RUN) && r_valid && (r_sc == SC_SAMPLE) &&
                      ((qout != r_exp_q) || (qbout != ~r_exp_q));
`ifdef DLATCH_TESTER_HALT_EN
  assign w_halt = w_mismatch;
`else
  assign w_halt = 1'b0;
`endif
  assign w_run_end  = w_halt || (w_step_end && w_last_vec);
  assign w_err_nxt  = (w_mismatch && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;
  assign w_k_nxt    = r_k + 8'd1;
  // mod-3 phase tracks k so the enable pattern needs no divider
  assign w_mod3_nxt = (r_mod3 == 2'd2) ? 2'd0 : r_mod3 + 2'd1;
  assign w_din_nxt  = w_k_nxt[0] ^ w_k_nxt[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_RUN;
      S_RUN:    if (w_run_end) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k     <= 8'd0;
      r_sc    <= '0;
      r_mod3  <= 2'd0;
      r_c     <= 1'b0;
      r_din   <= 1'b0;
      r_exp_q <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 8'd0;
      r_fail  <= 8'hFF;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k     <= 8'd0;
            r_sc    <= '0;
            r_mod3  <= 2'd0;
            r_c     <= 1'b0;
            r_din   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 8'd0;
            r_fail  <= 8'hFF;
            r_pass  <= 1'b0;
          end
        end
        S_RUN: begin
          r_err <= w_err_nxt;
          if (w_mismatch && (r_fail == 8'hFF)) r_fail <= r_k;
          if (w_run_end) begin
            r_c    <= 1'b0;
            r_din  <= 1'b0;
            r_pass <= (w_err_nxt == 8'd0);
          end else if (w_step_end) begin
            r_k    <= w_k_nxt;
            r_sc   <= '0;
            r_mod3 <= w_mod3_nxt;
            r_c    <= (w_mod3_nxt == 2'd2);
            r_din  <= w_din_nxt;
            // reference latch follows the transparent vectors only
            if (w_mod3_nxt == 2'd2) begin
              r_exp_q <= w_din_nxt;
              r_valid <= 1'b1;
            end
          end else begin
            r_sc <= r_sc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign c_out    = r_c;
  assign din_out  = r_din;
  assign pass     = r_pass;
  assign err_cnt  = r_err;
  assign fail_idx = r_fail;

endmodule

// File: tb/tb_dlatch_tester.sv
// tb/tb_dlatch_tester.sv - directed bench for dlatch_tester with a behavioural latch and fault modes
module tb_dlatch_tester;

  localparam int NUM_VEC     = 15;
  localparam int STEP_CYCLES = 10;
  localparam int SETTLE      = 2;

  typedef struct {
    logic [7:0] err;
    logic [7:0] fail;
    logic       pass;
    int         blen;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       qout;
  logic       qbout;
  logic       c_out;
  logic       din_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
  logic [7:0] fail_idx;

  logic       lq;
  int         mode = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];

  always #5 clk = ~clk;

  always_latch begin
    if (c_out) lq <= din_out;
  end

  assign qout  = (mode == 1) ? 1'b0 : lq;
  assign qbout = (mode == 1) ? 1'b1 : (mode == 2) ? qout : ~lq;

  dlatch_tester #(
    .NUM_VEC(NUM_VEC), .STEP_CYCLES(STEP_CYCLES), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .qout(qout), .qbout(qbout),
    .c_out(c_out), .din_out(din_out), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_idx(fail_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Independent run model: mode 0 good latch, 1 q stuck low, 2 qbar tied to q
  function automatic exp_t predict(input int m);
    exp_t e;
    logic valid = 1'b0;
    logic xq = 1'b0;
    logic q, qb, c, d;
    e.err  = 8'd0;
    e.fail = 8'hFF;
    e.blen = NUM_VEC * STEP_CYCLES;
    for (int k = 0; k < NUM_VEC; k++) begin
      c = ((k % 3) == 2);
      d = k[0] ^ k[2];
      if (c) begin xq = d; valid = 1'b1; end
      if (valid) begin
        q  = (m == 1) ? 1'b0 : xq;
        qb = (m == 1) ? 1'b1 : (m == 2) ? q : ~xq;
        if (q != xq || qb != ~xq) begin
          if (e.err != 8'hFF) e.err = e.err + 8'd1;
          if (e.fail == 8'hFF) e.fail = 8'(k);
`ifdef DLATCH_TESTER_HALT_EN
          e.blen = k * STEP_CYCLES + SETTLE + 1;
          break;
`endif
        end
      end
    end
    e.pass = (e.err == 8'd0);
    return e;
  endfunction

  task automatic run(input int m, input int extra_start_at, input string tag);
    exp_t e;
    int   n = 0;
    int   extra = 0;
    bit   seen = 0;
    mode = m;
    sb.push_back(predict(m));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin seen = 1; break; end
      if (busy) n++;
      start = (extra_start_at > 0 && n == extra_start_at);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(e.err));
    check({tag, "_fail_idx"}, 32'(fail_idx), 32'(e.fail));
    check({tag, "_pass"}, 32'(pass), 32'(e.pass));
    check({tag, "_busy_len"}, 32'(n), 32'(e.blen));
    check({tag, "_c_out_end"}, 32'(c_out), 32'd0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check({tag, "_no_rerun"}, 32'(extra), 32'd0);
    check({tag, "_err_hold"}, 32'(err_cnt), 32'(e.err));
  endtask

  initial begin
    int n;
    int dcount;
    repeat (3) @(negedge clk);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_din_out", 32'(din_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_fail_idx", 32'(fail_idx), 32'hFF);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(0, 0, "good");
    run(1, 0, "stuck0");
    run(2, 0, "qb_eq_q");
    run(0, 40, "restart_ignored");
    run(1, 0, "stuck0_again");

    // Abort mid-run during vector 6; qbar fault makes the pre-reset counters non-zero
`ifdef DLATCH_TESTER_HALT_EN
    mode = 0;
`else
    mode = 2;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && n < 65; i++) begin
      if (busy) n++;
      @(negedge clk);
    end
    check("abort_reached_vec6", 32'(n), 32'd65);
    rst = 1'b1;
    #1;
    check("abort_c_out", 32'(c_out), 32'd0);
    check("abort_din_out", 32'(din_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_err_cnt", 32'(err_cnt), 32'd0);
    check("abort_fail_idx", 32'(fail_idx), 32'hFF);
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    run(0, 0, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
